bounce_gen: RTL and testbench
=============================

# bounce_gen

Contact-bounce emulator: converts a clean level on `signal_in` into a realistic, pseudo-randomly chattering transition on `signal_out` that settles to the new level after a fixed bounce window. It is the inverse of `debounce_fsm`. It drives that debouncer (and the Sumador_Pulsos pulse path) on the board and in simulation without a real pushbutton. Timing parameters use the same `CLK_FREQ_HZ` / millisecond convention as the debouncer so the two pair directly.

## Interface
- `CLK_FREQ_HZ`, 100000, system clock frequency in Hz.
- `BOUNCE_TIME_MS`, 5, bounce window length in ms. `BOUNCE_CYCLES = CLK_FREQ_HZ*BOUNCE_TIME_MS/1000`, which is 500 at defaults.
- `GAP_BITS`, 4, width of the random inter-toggle gap. Gap is 1..2^GAP_BITS cycles.
- `LFSR_SEED`, 16'hACE1, LFSR reset value. Must be non-zero; elaboration error if zero.
- `clk` in 1: system clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `signal_in` in 1: clean, already-synchronous level command.
- `signal_out` out 1: bouncy output level.
- `busy` out 1: high while a bounce window is in progress.

## Operation
- Internal registers:
  - `stable`: last settled level.
  - `target`: level being settled to.
  - `win_cnt`: bounce-window down-counter, width clog2(BOUNCE_CYCLES).
  - `gap_cnt`: GAP_BITS+1 wide.
  - `lfsr`: 16-bit.
- LFSR:
  - 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1 (mask 16'hB400).
  - Advances every cycle, including IDLE.
  - Gap value = `lfsr[GAP_BITS-1:0] + 1`.
- FSM with two states, IDLE and BOUNCE.
- IDLE:
  - `signal_out = stable`; `busy = 0`.
  - If `signal_in != stable`: set `target <= signal_in`, `signal_out <= ~signal_out` (first edge), `win_cnt <= BOUNCE_CYCLES-1`, `gap_cnt <=` gap value, then go to BOUNCE.
- BOUNCE:
  - `busy = 1`. `win_cnt` decrements each cycle.
  - `gap_cnt` decrements each cycle. When `gap_cnt == 1`, toggle `signal_out` and reload `gap_cnt` with the current gap value.
  - When `win_cnt == 0`: set `signal_out <= target` and `stable <= target` regardless of toggle parity, then go to IDLE.
- Input change during BOUNCE (`signal_in != target`): set `target <= signal_in`, reload `win_cnt <= BOUNCE_CYCLES-1`, continue toggling.
  - The window is measured from the last input change.
  - `signal_out` is not forced that cycle.
- Input returning to `stable` during BOUNCE is handled by the same rule. The output settles to the original level after a full window.
- Simultaneous `win_cnt == 0` and a gap expiry: the settle wins and no extra toggle occurs.
- Simultaneous `win_cnt == 0` and an input change: the input change wins and the window reloads.

## Timing
- Reset values: `signal_out = 0`, `busy = 0`, `stable = 0`, `target = 0`, `lfsr = LFSR_SEED`, state IDLE.
- Reset mid-BOUNCE aborts immediately; the outputs take their reset values on that edge.
- Latency:
  - A change of `signal_in` sampled at edge k inverts `signal_out` and raises `busy` at edge k.
  - `signal_out == target` and `busy` falls at edge k+BOUNCE_CYCLES.
- Inside the window:
  - Consecutive toggles are separated by 1..2^GAP_BITS cycles.
  - `signal_out` is never held constant longer than 2^GAP_BITS cycles.
- Output is fully registered; there is no combinational path from `signal_in` to `signal_out`.
- The sequence is deterministic for a given seed and reset point, so test waveforms are reproducible.

## Structure
- Shared package (`bounce_pkg`) holds:
  - State encoding constants (IDLE=0, BOUNCE=1).
  - LFSR mask 16'hB400 and default seed.
  - `BOUNCE_CYCLES` computation function, reusable by `debounce_fsm` benches.
- One sub-module, `lfsr16`, with ports `clk`, `rst`, `seed` (parameter) and `q[15:0]`. It free-runs every cycle.
- FSM, counters and output register live in `bounce_gen`.

## Test plan
- Reset, `signal_in=0` for 100 cycles → `signal_out=0`, `busy=0` throughout; `lfsr` steps from 16'hACE1.
- `signal_in` 0→1 at edge k, held → `signal_out` toggles at k, at least 2 toggles total, each gap ≤16 cycles, `busy` falls at k+500, `signal_out=1` from then on.
- 1→0 with held input → mirror behaviour; `signal_out=0` at k+500.
- `signal_in` 0→1, then 1→0 at k+200, then held → `busy` stays high until k+700, final `signal_out=0`, `stable` unchanged at 0.
- Assert `rst` at k+250 of a bounce → `signal_out=0`, `busy=0` on the reset edge; no toggles while `rst=1`.
- Chain into `debounce_fsm` (CLK_FREQ_HZ=100000, DEBOUNCE_TIME_MS=7), drive 0→1 and 1→0 → debouncer output shows exactly one rising and one falling edge.

Source files
------------

// File: rtl/bounce_pkg.sv
// Shared definitions for the contact-bounce emulator: state encoding,
// LFSR constants and the bounce-window length helper (also usable by
// debouncer benches that need the same millisecond-to-cycle conversion).
package bounce_pkg;

    // Two-state bounce FSM encoding.
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_BOUNCE = 1'b1
    } state_e;

    // Galois feedback mask for x^16 + x^14 + x^13 + x^11 + 1.
    localparam logic [15:0] LFSR_MASK         = 16'hB400;
    localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

    // Number of clock cycles in a window of time_ms milliseconds.
    function automatic int unsigned bounce_cycles(input int unsigned clk_freq_hz,
                                                  input int unsigned time_ms);
        longint unsigned prod;
        prod = longint'(clk_freq_hz) * longint'(time_ms);
        return int'(prod / 64'd1000);
    endfunction

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bounce_gen_lfsr16.sv
// Free-running 16-bit Galois LFSR. It supplies the pseudo-random gap
// lengths between output toggles and steps on every clock that is not
// in reset, so the toggle pattern is reproducible from the reset point.
module lfsr16
    import bounce_pkg::*;
#(
    parameter logic [15:0] SEED = LFSR_DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] q
);

    // An all-zero seed would lock the register at zero forever.
    if (SEED == 16'h0000) begin : g_bad_seed
        $error("lfsr16: SEED must be non-zero");
    end

    logic [15:0] q_q;
    logic [15:0] q_d;

    // Next LFSR value: shift right, fold the feedback mask in when bit 0 falls out.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
        q_d = {1'b0, q_q[15:1]};
        if (q_q[0]) begin
            q_d = q_d ^ LFSR_MASK;
        end
    end

    // LFSR state register with synchronous reset to the seed.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            q_q <= SEED;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/bounce_gen.sv
// Contact-bounce emulator. A change on signal_in starts a bounce window
// during which signal_out chatters with pseudo-random gaps, then settles
// to the commanded level. A further input change restarts the window.
module bounce_gen
    import bounce_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ    = 100000,
    parameter int unsigned BOUNCE_TIME_MS = 5,
    parameter int unsigned GAP_BITS       = 4,
    parameter logic [15:0] LFSR_SEED      = LFSR_DEFAULT_SEED
) (
    input  logic clk,
    input  logic rst,
    input  logic signal_in,
    output logic signal_out,
    output logic busy
);

    localparam int unsigned BOUNCE_CYCLES = bounce_cycles(CLK_FREQ_HZ, BOUNCE_TIME_MS);
    localparam int unsigned WIN_W         = cnt_width(BOUNCE_CYCLES);
    localparam int unsigned GAP_W         = GAP_BITS + 1;

    localparam logic [WIN_W-1:0] WIN_RELOAD = WIN_W'(BOUNCE_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_ONE    = GAP_W'(1);

    if (BOUNCE_CYCLES < 1) begin : g_bad_window
        $error("bounce_gen: bounce window must be at least one cycle");
    end
    if (GAP_BITS < 1 || GAP_BITS > 15) begin : g_bad_gap
        $error("bounce_gen: GAP_BITS must be in 1..15");
    end

    // ------------------------------------------------------------------
    // Random source
    // ------------------------------------------------------------------
    logic [15:0]      lfsr;
    logic [GAP_W-1:0] gap_val;
    logic             lfsr_unused;

    lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk (clk),
        .rst (rst),
        .q   (lfsr)
    );

    // Gap of 1..2^GAP_BITS cycles from the low LFSR bits; upper bits are not needed.
    assign gap_val     = {1'b0, lfsr[GAP_BITS-1:0]} + GAP_ONE;
    assign lfsr_unused = ^lfsr[15:GAP_BITS];

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e           state_q,      state_d;
    logic             signal_out_q, signal_out_d;
    logic             stable_q,     stable_d;
    logic             target_q,     target_d;
    logic [WIN_W-1:0] win_cnt_q,    win_cnt_d;
    logic [GAP_W-1:0] gap_cnt_q,    gap_cnt_d;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: leave IDLE on any input change, settle when the window
    // expires unless the input moved again on that same cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (signal_in != stable_q) begin
                    state_d = ST_BOUNCE;
                end
            end
            ST_BOUNCE: begin
                if (signal_in == target_q && win_cnt_q == '0) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: busy follows the state, the level is always a flop output.
    always_comb begin
        signal_out = signal_out_q;
        busy       = 1'b0;
        case (state_q)
            ST_IDLE:   busy = 1'b0;
            ST_BOUNCE: busy = 1'b1;
            default:   busy = 1'b0;
        endcase
    end

    // Datapath: first edge on entry, random toggles inside the window,
    // window restart on input change, forced settle on expiry.
    always_comb begin
        signal_out_d = signal_out_q;
        stable_d     = stable_q;
        target_d     = target_q;
        win_cnt_d    = win_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (signal_in != stable_q) begin
                    target_d     = signal_in;
                    signal_out_d = ~signal_out_q;
                    win_cnt_d    = WIN_RELOAD;
                    gap_cnt_d    = gap_val;
                end
            end
            ST_BOUNCE: begin
                // Gap timer runs independently of the window.
                if (gap_cnt_q == GAP_ONE) begin
                    signal_out_d = ~signal_out_q;
                    gap_cnt_d    = gap_val;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_ONE;
                end

                if (signal_in != target_q) begin
                    // New command restarts the window; the level is not forced.
                    target_d  = signal_in;
                    win_cnt_d = WIN_RELOAD;
                end else if (win_cnt_q == '0) begin
                    // Settle overrides any toggle that was due this cycle.
                    signal_out_d = target_q;
                    stable_d     = target_q;
                    gap_cnt_d    = gap_cnt_q;
                end else begin
                    win_cnt_d = win_cnt_q - WIN_W'(1);
                end
            end
            default: ;
        endcase
    end

    // Datapath registers; reset clears all of them so a mid-window reset aborts cleanly.
    always_ff @(posedge clk) begin
        if (rst) begin
            signal_out_q <= 1'b0;
            stable_q     <= 1'b0;
            target_q     <= 1'b0;
            win_cnt_q    <= '0;
            gap_cnt_q    <= '0;
        end else begin
            signal_out_q <= signal_out_d;
            stable_q     <= stable_d;
            target_q     <= target_d;
            win_cnt_q    <= win_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
        end
    end

endmodule

// File: tb/tb_bounce_gen.sv
// Directed bench for bounce_gen at default parameters (500-cycle window,
// gaps of 1..16 cycles). A small reference debouncer (700-cycle stability
// requirement) stands in for debounce_fsm in the chained scenario.
module tb_bounce_gen;

    localparam int BC      = 500;
    localparam int MAX_GAP = 16;
    localparam int DB_CYC  = 700;

    logic clk = 1'b0;
    logic rst;
    logic signal_in;
    logic signal_out;
    logic busy;

    int total = 0;
    int bad   = 0;

    bounce_gen #(
        .CLK_FREQ_HZ    (100000),
        .BOUNCE_TIME_MS (5),
        .GAP_BITS       (4),
        .LFSR_SEED      (16'hACE1)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .signal_in  (signal_in),
        .signal_out (signal_out),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Reference debouncer: output follows signal_out once it has differed for DB_CYC cycles.
    logic db_q;
    int   db_cnt;
    always @(posedge clk) begin
        if (rst) begin
            db_q   <= 1'b0;
            db_cnt <= 0;
        end else if (signal_out != db_q) begin
            if (db_cnt == DB_CYC - 1) begin
                db_q   <= signal_out;
                db_cnt <= 0;
            end else begin
                db_cnt <= db_cnt + 1;
            end
        end else begin
            db_cnt <= 0;
        end
    end

    // Drive a new level (sampled at the next edge, called edge k) and watch
    // the following cycles. Called just after an active edge.
    task automatic watch(input logic lvl, input int rev_at, input int horizon,
                         output int toggles, output int max_hold, output int idle_at,
                         output logic first_out, output logic first_busy,
                         output int late_changes, output int stable_changes);
        logic prev;
        logic prev_stable;
        int   last;
        prev        = signal_out;
        prev_stable = u_dut.stable_q;
        signal_in   = lvl;
        @(posedge clk); #1;
        first_out      = signal_out;
        first_busy     = busy;
        toggles        = (signal_out != prev) ? 1 : 0;
        prev           = signal_out;
        last           = 0;
        max_hold       = 0;
        idle_at        = -1;
        late_changes   = 0;
        stable_changes = 0;
        for (int n = 1; n <= horizon; n++) begin
            if (n == rev_at) signal_in = ~lvl;
            @(posedge clk); #1;
            if (u_dut.stable_q != prev_stable) stable_changes++;
            prev_stable = u_dut.stable_q;
            if (idle_at < 0) begin
                if (signal_out != prev) begin
                    toggles++;
                    if (n - last > max_hold) max_hold = n - last;
                    last = n;
                end
                if (!busy) begin
                    idle_at = n;
                    if (n - last > max_hold) max_hold = n - last;
                end
            end else if (signal_out != prev) begin
                late_changes++;
            end
            prev = signal_out;
        end
    endtask

    task automatic test_reset();
        logic [15:0] exp_seq [4];
        int          noisy;
        exp_seq = '{16'hE270, 16'h7138, 16'h389C, 16'h1C4E};
        rst       = 1'b1;
        signal_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (signal_out !== 1'b0) begin bad++; $display("FAIL reset_out: got %b expected 0", signal_out); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
        total++; if (u_dut.u_lfsr.q !== 16'hACE1) begin bad++; $display("FAIL reset_lfsr: got %h expected ace1", u_dut.u_lfsr.q); end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            total++;
            if (u_dut.u_lfsr.q !== exp_seq[i]) begin
                bad++; $display("FAIL lfsr_step%0d: got %h expected %h", i, u_dut.u_lfsr.q, exp_seq[i]);
            end
        end
        noisy = 0;
        for (int i = 0; i < 96; i++) begin
            @(posedge clk); #1;
            if (signal_out !== 1'b0 || busy !== 1'b0) noisy++;
        end
        total++; if (noisy !== 0) begin bad++; $display("FAIL idle_quiet: got %0d noisy cycles expected 0", noisy); end
    endtask

    // Single clean transition to lvl; checks first edge, chatter, settle time.
    task automatic test_edge(input logic lvl, input string tag);
        int   toggles, max_hold, idle_at, late, stab;
        logic f_out, f_busy;
        watch(lvl, 0, BC + 30, toggles, max_hold, idle_at, f_out, f_busy, late, stab);
        total++; if (f_out !== lvl) begin bad++; $display("FAIL %s_first_edge: got %b expected %b", tag, f_out, lvl); end
        total++; if (f_busy !== 1'b1) begin bad++; $display("FAIL %s_busy_rise: got %b expected 1", tag, f_busy); end
        total++; if (!(toggles >= 2)) begin bad++; $display("FAIL %s_toggles: got %0d expected >=2", tag, toggles); end
        total++; if (!(max_hold <= MAX_GAP)) begin bad++; $display("FAIL %s_max_hold: got %0d expected <=%0d", tag, max_hold, MAX_GAP); end
        total++; if (idle_at !== BC) begin bad++; $display("FAIL %s_busy_fall: got %0d expected %0d", tag, idle_at, BC); end
        total++; if (signal_out !== lvl) begin bad++; $display("FAIL %s_final: got %b expected %b", tag, signal_out, lvl); end
        total++; if (late !== 0) begin bad++; $display("FAIL %s_after_settle: got %0d changes expected 0", tag, late); end
        total++; if (stab !== 1) begin bad++; $display("FAIL %s_stable_updates: got %0d expected 1", tag, stab); end
    endtask

    // 0->1 then back to 0 at rev_at: the window restarts from the reversal.
    task automatic test_reversal(input int rev_at, input string tag);
        int   toggles, max_hold, idle_at, late, stab;
        logic f_out, f_busy;
        watch(1'b1, rev_at, rev_at + BC + 30, toggles, max_hold, idle_at, f_out, f_busy, late, stab);
        total++; if (f_out !== 1'b1) begin bad++; $display("FAIL %s_first_edge: got %b expected 1", tag, f_out); end
        total++; if (idle_at !== rev_at + BC) begin bad++; $display("FAIL %s_busy_fall: got %0d expected %0d", tag, idle_at, rev_at + BC); end
        total++; if (!(max_hold <= MAX_GAP)) begin bad++; $display("FAIL %s_max_hold: got %0d expected <=%0d", tag, max_hold, MAX_GAP); end
        total++; if (signal_out !== 1'b0) begin bad++; $display("FAIL %s_final: got %b expected 0", tag, signal_out); end
        total++; if (stab !== 0) begin bad++; $display("FAIL %s_stable_updates: got %0d expected 0", tag, stab); end
        total++; if (late !== 0) begin bad++; $display("FAIL %s_after_settle: got %0d changes expected 0", tag, late); end
    endtask

    task automatic test_reset_mid_bounce();
        int noisy, lfsr_moves;
        signal_in = 1'b1;
        @(posedge clk); #1;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL rstmid_busy_rise: got %b expected 1", busy); end
        for (int n = 1; n < 250; n++) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        total++; if (signal_out !== 1'b0) begin bad++; $display("FAIL rstmid_out: got %b expected 0", signal_out); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
        noisy      = 0;
        lfsr_moves = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (signal_out !== 1'b0 || busy !== 1'b0) noisy++;
            if (u_dut.u_lfsr.q !== 16'hACE1) lfsr_moves++;
        end
        total++; if (noisy !== 0) begin bad++; $display("FAIL rstmid_hold_quiet: got %0d noisy cycles expected 0", noisy); end
        total++; if (lfsr_moves !== 0) begin bad++; $display("FAIL rstmid_lfsr_held: got %0d moves expected 0", lfsr_moves); end
        signal_in = 1'b0;
        rst       = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        total++; if (busy !== 1'b0 || signal_out !== 1'b0) begin
            bad++; $display("FAIL rstmid_release: got busy=%b out=%b expected 0/0", busy, signal_out);
        end
    endtask

    // Bouncy 0->1 then 1->0 into the reference debouncer: one clean pulse.
    task automatic test_debounce_chain();
        int   rises, falls;
        logic prev;
        rises = 0;
        falls = 0;
        prev  = db_q;
        for (int phase = 0; phase < 2; phase++) begin
            signal_in = (phase == 0) ? 1'b1 : 1'b0;
            for (int i = 0; i < 1300; i++) begin
                @(posedge clk); #1;
                if (db_q === 1'b1 && prev === 1'b0) rises++;
                if (db_q === 1'b0 && prev === 1'b1) falls++;
                prev = db_q;
            end
        end
        total++; if (rises !== 1) begin bad++; $display("FAIL chain_rises: got %0d expected 1", rises); end
        total++; if (falls !== 1) begin bad++; $display("FAIL chain_falls: got %0d expected 1", falls); end
    endtask

    initial begin
        rst       = 1'b1;
        signal_in = 1'b0;
        test_reset();
        test_edge(1'b1, "rise");
        test_edge(1'b0, "fall");
        test_reversal(200, "reverse200");
        test_reversal(BC, "reverse_at_settle");
        test_reset_mid_bounce();
        test_debounce_chain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
